// File: rtl/roi_shift_driver.sv
// ---------------------------------------------------------------------------
// roi_shift_driver
//
// Host end of the ROI harness serial protocol. A frame is accepted in IDLE,
// the latched stimulus is shifted out MSB first on di for N cycles while the
// harness response is shifted in from sdo, and then a single STROBE cycle
// makes the harness load its input vector and capture the ROI output. The
// response collected in frame F therefore belongs to the strobe of frame F-1.
//
// Parameters
//   N          frame length in bits (>= 2), equals the harness register width
//
// Ports
//   clk        clock, all state on the rising edge
//   rst_n      asynchronous active-low reset
//   start      frame request, taken only while ready=1
//   ready      high only in IDLE
//   tx_data    parallel stimulus, latched when start is accepted
//   rx_data    parallel response of the previous frame, held between strobes
//   rx_valid   one-cycle pulse in the STROBE cycle, rx_data valid
//   rx_stale   1 while no strobe has completed since reset (qualifies rx_valid)
//   di         serial data to the harness, 0 outside SHIFT
//   stb        harness load/capture strobe, high only in STROBE
//   sdo        serial data from the harness (the harness pin is "do", which
//              is a reserved word in SystemVerilog)
//   frame_cnt  completed-frame count, constant 0 unless the counter is built
//   state_dbg  current FSM state (IDLE=0, SHIFT=1, STROBE=2)
//
// Build option
//   ROI_SHIFT_DRIVER_FRAME_CNT_EN  when defined, frame_cnt counts STROBE
//   cycles and wraps 16'hFFFF -> 16'h0000; when undefined no counter exists.
//
// Handshake: a frame request is a single-cycle start/ready transfer; start is
// sampled only on a rising edge where ready=1, and is ignored otherwise.
// ---------------------------------------------------------------------------
module roi_shift_driver #(
    parameter int N = 256
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    output logic         ready,
    input  logic [N-1:0] tx_data,
    output logic [N-1:0] rx_data,
    output logic         rx_valid,
    output logic         rx_stale,
    output logic         di,
    output logic         stb,
    input  logic         sdo,
    output logic [15:0]  frame_cnt,
    output logic [1:0]   state_dbg
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SHIFT  = 2'd1,
        ST_STROBE = 2'd2
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] bit_cnt;
    logic [N-1:0]  tx_sr;
    logic [N-1:0]  rx_sr;
    logic          strobe_seen;
    logic          last_bit;

    // bit_cnt runs 0..N-1 inside SHIFT; N-1 fits in CW bits so it never wraps
    assign last_bit  = (bit_cnt == CW'(N - 1));
    assign state_dbg = state;

    // -----------------------------------------------------------------------
    // Next-state and output decode
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        stb       = 1'b0;
        rx_valid  = 1'b0;
        di        = 1'b0;
        rx_stale  = ~strobe_seen;
        case (state)
            ST_IDLE: begin
                ready = 1'b1;
                if (start) state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                di = tx_sr[N-1];
                if (last_bit) state_nxt = ST_STROBE;
            end
            ST_STROBE: begin
                stb       = 1'b1;
                rx_valid  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // -----------------------------------------------------------------------
    // State register and datapath
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            tx_sr       <= '0;
            rx_sr       <= '0;
            rx_data     <= '0;
            strobe_seen <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        tx_sr   <= tx_data;
                        bit_cnt <= '0;
                    end
                end
                ST_SHIFT: begin
                    tx_sr <= {tx_sr[N-2:0], 1'b0};
                    // The bit sampled at the end of shift cycle k enters at
                    // position 0 and is pushed up N-1-k more times, so the
                    // first sample ends in rx position N-1.
                    rx_sr <= {rx_sr[N-2:0], sdo};
                    if (last_bit) begin
                        // Publish the complete response so rx_data is whole
                        // during the STROBE cycle and stable until the next.
                        rx_data <= {rx_sr[N-2:0], sdo};
                        bit_cnt <= '0;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
                ST_STROBE: begin
                    strobe_seen <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // -----------------------------------------------------------------------
    // Completed-frame counter (optional)
    // -----------------------------------------------------------------------
`ifdef ROI_SHIFT_DRIVER_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
        end else if (state == ST_STROBE) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign frame_cnt = frame_cnt_q;
`else
    assign frame_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_roi_shift_driver.sv
module tb_roi_shift_driver;

  localparam int N   = 256;
  localparam int FRM = N + 2;

  logic         clk;
  logic         rst_n;
  logic         start;
  logic         ready;
  logic [N-1:0] tx_data;
  logic [N-1:0] rx_data;
  logic         rx_valid;
  logic         rx_stale;
  logic         di;
  logic         stb;
  logic         sdo;
  logic [15:0]  frame_cnt;
  logic [1:0]   state_dbg;

  int total = 0;
  int bad   = 0;

  roi_shift_driver #(.N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .ready     (ready),
    .tx_data   (tx_data),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .rx_stale  (rx_stale),
    .di        (di),
    .stb       (stb),
    .sdo       (sdo),
    .frame_cnt (frame_cnt),
    .state_dbg (state_dbg)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural harness: input register shifts di in, output register shifts
  // out on sdo, both only during the shift phase; the strobe loads the input
  // vector and captures the ROI output (identity) into the output register.
  logic [N-1:0] h_in;
  logic [N-1:0] h_out;
  initial begin
    h_in  = '0;
    h_out = '0;
  end
  always @(posedge clk) begin
    if (stb) begin
      h_out <= h_in;
    end else if (!ready) begin
      h_in  <= {h_in[N-2:0], di};
      h_out <= {h_out[N-2:0], 1'b0};
    end
  end
  assign sdo = h_out[N-1];

  // driver: run one frame, return the response seen at its rx_valid pulse
  task automatic run_frame(input logic [N-1:0] v, output logic found,
                           output logic [N-1:0] data, output logic stale);
    found = 1'b0;
    data  = '0;
    stale = 1'b0;
    for (int i = 0; i < N + 8 && !ready; i++) @(negedge clk);
    tx_data = v;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < N + 8; i++) begin
      if (rx_valid) begin
        found = 1'b1;
        data  = rx_data;
        stale = rx_stale;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic wait_ready;
    for (int i = 0; i < N + 8 && !ready; i++) @(negedge clk);
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    start   = 1'b0;
    tx_data = '0;
    repeat (3) @(negedge clk);
    total++; if (ready !== 1'b1)     begin bad++; $display("FAIL reset_ready got=%b exp=1", ready); end
    total++; if (stb !== 1'b0)       begin bad++; $display("FAIL reset_stb got=%b exp=0", stb); end
    total++; if (di !== 1'b0)        begin bad++; $display("FAIL reset_di got=%b exp=0", di); end
    total++; if (rx_valid !== 1'b0)  begin bad++; $display("FAIL reset_rx_valid got=%b exp=0", rx_valid); end
    total++; if (rx_stale !== 1'b1)  begin bad++; $display("FAIL reset_rx_stale got=%b exp=1", rx_stale); end
    total++; if (rx_data !== '0)     begin bad++; $display("FAIL reset_rx_data got=%h exp=0", rx_data); end
    total++; if (frame_cnt !== 16'd0) begin bad++; $display("FAIL reset_frame_cnt got=%h exp=0", frame_cnt); end
    rst_n = 1'b1;
    @(negedge clk);
    total++; if (ready !== 1'b1)     begin bad++; $display("FAIL reset_release_ready got=%b exp=1", ready); end
  endtask

  // tx_data=1: di high only in shift cycle 255, stb in cycle 257
  task automatic test_single_bit;
    logic exp_di;
    logic exp_stb;
    tx_data = {{(N-1){1'b0}}, 1'b1};
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 1; c <= N + 1; c++) begin
      exp_di  = (c == N);
      exp_stb = (c == N + 1);
      total++; if (di !== exp_di)   begin bad++; $display("FAIL single_di c=%0d got=%b exp=%b", c, di, exp_di); end
      total++; if (stb !== exp_stb) begin bad++; $display("FAIL single_stb c=%0d got=%b exp=%b", c, stb, exp_stb); end
      if (c == N + 1) begin
        total++; if (rx_valid !== 1'b1) begin bad++; $display("FAIL single_rx_valid got=%b exp=1", rx_valid); end
        total++; if (rx_stale !== 1'b1) begin bad++; $display("FAIL single_rx_stale got=%b exp=1", rx_stale); end
      end
      @(negedge clk);
    end
    total++; if (ready !== 1'b1) begin bad++; $display("FAIL single_back_idle got=%b exp=1", ready); end
  endtask

  // identity ROI: frame A then frame B returns A at B's rx_valid
  task automatic test_identity;
    logic         found;
    logic [N-1:0] data;
    logic         stale;
    logic [N-1:0] a_val;
    a_val = {32{8'hA5}};
    run_frame(a_val, found, data, stale);
    total++; if (found !== 1'b1) begin bad++; $display("FAIL ident_a_valid got=%b exp=1", found); end
    total++; if (data !== {{(N-1){1'b0}}, 1'b1}) begin bad++; $display("FAIL ident_a_data got=%h exp=1", data); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL ident_a_stale got=%b exp=0", stale); end
    run_frame('0, found, data, stale);
    total++; if (found !== 1'b1) begin bad++; $display("FAIL ident_b_valid got=%b exp=1", found); end
    total++; if (data !== a_val) begin bad++; $display("FAIL ident_b_data got=%h exp=%h", data, a_val); end
    total++; if (stale !== 1'b0) begin bad++; $display("FAIL ident_b_stale got=%b exp=0", stale); end
    repeat (5) @(negedge clk);
    total++; if (rx_data !== a_val) begin bad++; $display("FAIL ident_hold got=%h exp=%h", rx_data, a_val); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL ident_valid_low got=%b exp=0", rx_valid); end
  endtask

  // tx_data changes during SHIFT must not alter the serialized frame
  task automatic test_latch;
    logic [N-1:0] p_val;
    logic [N-1:0] cap;
    logic         found;
    logic [N-1:0] data;
    logic         stale;
    p_val = {8{32'h1234_5678}};
    cap   = '0;
    wait_ready();
    tx_data = p_val;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < N; k++) begin
      tx_data = {8{$urandom_range(32'hFFFF_FFFF, 0)}};
      cap[N-1-k] = di;
      @(negedge clk);
    end
    total++; if (cap !== p_val) begin bad++; $display("FAIL latch_serial got=%h exp=%h", cap, p_val); end
    total++; if (stb !== 1'b1)  begin bad++; $display("FAIL latch_stb got=%b exp=1", stb); end
    total++; if (di !== 1'b0)   begin bad++; $display("FAIL latch_di_strobe got=%b exp=0", di); end
    run_frame('0, found, data, stale);
    total++; if (data !== p_val) begin bad++; $display("FAIL latch_echo got=%h exp=%h", data, p_val); end
  endtask

  // start held high for three frames: stb every N+2 cycles
  task automatic test_back_to_back;
    int   stb_at[$];
    logic exp_rdy;
    wait_ready();
    tx_data = {N{1'b1}};
    start   = 1'b1;
    for (int c = 0; c < 3 * FRM; c++) begin
      exp_rdy = ((c % FRM) == 0);
      total++; if (ready !== exp_rdy) begin bad++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, ready, exp_rdy); end
      if (stb) stb_at.push_back(c);
      if (c == 3 * FRM - 1) start = 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    total++; if (stb_at.size() != 3) begin bad++; $display("FAIL b2b_stb_count got=%0d exp=3", stb_at.size()); end
    if (stb_at.size() == 3) begin
      total++; if (stb_at[0] != N + 1)      begin bad++; $display("FAIL b2b_first got=%0d exp=%0d", stb_at[0], N + 1); end
      total++; if (stb_at[1] - stb_at[0] != FRM) begin bad++; $display("FAIL b2b_gap1 got=%0d exp=%0d", stb_at[1] - stb_at[0], FRM); end
      total++; if (stb_at[2] - stb_at[1] != FRM) begin bad++; $display("FAIL b2b_gap2 got=%0d exp=%0d", stb_at[2] - stb_at[1], FRM); end
    end
  endtask

  // reset in shift cycle 100
  task automatic test_reset_mid;
    int           nvalid;
    logic         found;
    logic [N-1:0] data;
    logic         stale;
    wait_ready();
    tx_data = {N{1'b1}};
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (100) @(negedge clk);
    total++; if (di !== 1'b1) begin bad++; $display("FAIL mid_di_before got=%b exp=1", di); end
    rst_n = 1'b0;
    #1;
    total++; if (ready !== 1'b1)    begin bad++; $display("FAIL mid_ready got=%b exp=1", ready); end
    total++; if (stb !== 1'b0)      begin bad++; $display("FAIL mid_stb got=%b exp=0", stb); end
    total++; if (di !== 1'b0)       begin bad++; $display("FAIL mid_di got=%b exp=0", di); end
    total++; if (rx_stale !== 1'b1) begin bad++; $display("FAIL mid_stale got=%b exp=1", rx_stale); end
    total++; if (rx_data !== '0)    begin bad++; $display("FAIL mid_rx_data got=%h exp=0", rx_data); end
    @(negedge clk);
    rst_n  = 1'b1;
    nvalid = 0;
    for (int i = 0; i < 300; i++) begin
      if (rx_valid) nvalid++;
      @(negedge clk);
    end
    total++; if (nvalid != 0) begin bad++; $display("FAIL mid_no_valid got=%0d exp=0", nvalid); end
    run_frame('0, found, data, stale);
    total++; if (found !== 1'b1) begin bad++; $display("FAIL mid_next_valid got=%b exp=1", found); end
    total++; if (stale !== 1'b1) begin bad++; $display("FAIL mid_next_stale got=%b exp=1", stale); end
  endtask

  task automatic test_frame_cnt;
    logic         found;
    logic [N-1:0] data;
    logic         stale;
`ifdef ROI_SHIFT_DRIVER_FRAME_CNT_EN
    wait_ready();
    force dut.frame_cnt_q = 16'hFFFF;
    @(negedge clk);
    release dut.frame_cnt_q;
    total++; if (frame_cnt !== 16'hFFFF) begin bad++; $display("FAIL cnt_preload got=%h exp=ffff", frame_cnt); end
    run_frame('0, found, data, stale);
    @(negedge clk);
    total++; if (frame_cnt !== 16'h0000) begin bad++; $display("FAIL cnt_wrap got=%h exp=0000", frame_cnt); end
    run_frame('0, found, data, stale);
    @(negedge clk);
    total++; if (frame_cnt !== 16'h0001) begin bad++; $display("FAIL cnt_inc got=%h exp=0001", frame_cnt); end
`else
    for (int f = 0; f < 5; f++) begin
      run_frame('0, found, data, stale);
      total++; if (found !== 1'b1) begin bad++; $display("FAIL cnt_frame_valid f=%0d got=%b exp=1", f, found); end
    end
    @(negedge clk);
    total++; if (frame_cnt !== 16'h0000) begin bad++; $display("FAIL cnt_const got=%h exp=0000", frame_cnt); end
`endif
  endtask

  initial begin
    test_reset();
    test_single_bit();
    test_identity();
    test_latch();
    test_back_to_back();
    test_reset_mid();
    test_frame_cnt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
